// File: rtl/wb_ic_pkg.sv
// wb_ic_pkg: shared state, error-code constants and width helper for the Wishbone 1-to-N interconnect
package wb_ic_pkg;
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACTIVE = 2'd1;
    localparam logic [1:0] S_DECERR = 2'd2;
    typedef logic [1:0] state_t;
    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_DECODE  = 2'b01,
        ERR_TIMEOUT = 2'b10,
        ERR_TARGET  = 2'b11
    } err_code_t;
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/wb_addr_decoder.sv
// wb_addr_decoder: combinational base/mask address match, lowest matching index wins
module wb_addr_decoder #(
    parameter int N = 4,
    parameter int ADR_W = 32,
    parameter int IDX_W = 2,
    parameter logic [N*ADR_W-1:0] BASE = '0,
    parameter logic [N*ADR_W-1:0] MASK = '0
) (
    input  logic [ADR_W-1:0] adr,
    output logic             hit,
    output logic [IDX_W-1:0] idx
);
    // Scan from the top down so the lowest matching index is written last
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if ((adr & MASK[i*ADR_W +: ADR_W]) == (BASE[i*ADR_W +: ADR_W] & MASK[i*ADR_W +: ADR_W])) begin
                hit = 1'b1;
                idx = IDX_W'(i);
            end
        end
    end
endmodule

// File: rtl/wb_1ton_interconnect.sv
// wb_1ton_interconnect: single-initiator Wishbone classic fan-out with decode error, watchdog and error log
module wb_1ton_interconnect
    import wb_ic_pkg::*;
#(
    parameter int NUM_TARGETS = 4,
    parameter int ADR_W = 32,
    parameter int DAT_W = 32,
    localparam int SEL_W = DAT_W / 8,
    parameter logic [NUM_TARGETS*ADR_W-1:0] TGT_BASE = {32'h9000_0000, 32'h0400_0000, 32'h0000_0000, 32'h9E00_0000},
    parameter logic [NUM_TARGETS*ADR_W-1:0] TGT_MASK = {4{32'hFF00_0000}},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                         wb_clk_i,
    input  logic                         wb_rst_n_i,
    input  logic                         m_cyc_i,
    input  logic                         m_stb_i,
    input  logic                         m_we_i,
    input  logic [ADR_W-1:0]             m_adr_i,
    input  logic [SEL_W-1:0]             m_sel_i,
    input  logic [DAT_W-1:0]             m_dat_i,
    output logic [DAT_W-1:0]             m_dat_o,
    output logic                         m_ack_o,
    output logic                         m_err_o,
    output logic [NUM_TARGETS-1:0]       t_cyc_o,
    output logic [NUM_TARGETS-1:0]       t_stb_o,
    output logic [NUM_TARGETS-1:0]       t_we_o,
    output logic [ADR_W-1:0]             t_adr_o,
    output logic [SEL_W-1:0]             t_sel_o,
    output logic [DAT_W-1:0]             t_dat_o,
    input  logic [NUM_TARGETS*DAT_W-1:0] t_dat_i,
    input  logic [NUM_TARGETS-1:0]       t_ack_i,
    input  logic [NUM_TARGETS-1:0]       t_err_i,
    output logic                         err_stb_o,
    output logic [1:0]                   err_code_o,
    output logic [ADR_W-1:0]             err_adr_o
);
    localparam int IDX_W = clog2w(NUM_TARGETS);
    localparam int CNT_W = clog2w(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    if (NUM_TARGETS < 1 || NUM_TARGETS > 16) begin : g_bad_num_targets
        $error("wb_1ton_interconnect: NUM_TARGETS must be in 1..16");
    end

    state_t                 state_q;
    state_t                 state_d;
    logic [IDX_W-1:0]       sel_q;
    logic [IDX_W-1:0]       dec_idx;
    logic                   dec_hit;
    logic [ADR_W-1:0]       adr_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   req;
    logic                   live;
    logic                   rsp_ack;
    logic                   rsp_err;
    logic                   tmo;
    logic [NUM_TARGETS-1:0] sel_oh;
    logic [1:0]             err_code_d;
    logic [DAT_W-1:0]       t_dat_a [NUM_TARGETS];

    for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_unpack
        assign t_dat_a[i] = t_dat_i[i*DAT_W +: DAT_W];
    end

    wb_addr_decoder #(
        .N     (NUM_TARGETS),
        .ADR_W (ADR_W),
        .IDX_W (IDX_W),
        .BASE  (TGT_BASE),
        .MASK  (TGT_MASK)
    ) u_dec (
        .adr (m_adr_i),
        .hit (dec_hit),
        .idx (dec_idx)
    );

    // Route the selected target, resolve responses (err beats ack, response beats watchdog) and pick next state
    always_comb begin
        req        = m_cyc_i & m_stb_i;
        live       = (state_q == S_ACTIVE) & m_cyc_i;
        rsp_ack    = t_ack_i[sel_q];
        rsp_err    = t_err_i[sel_q];
        tmo        = live & (TIMEOUT_CYCLES != 0) & (cnt_q == CNT_LAST) & ~(rsp_ack | rsp_err);
        sel_oh     = NUM_TARGETS'(1) << sel_q;
        t_cyc_o    = (live & ~tmo) ? sel_oh : '0;
        t_stb_o    = t_cyc_o;
        t_we_o     = m_we_i ? t_cyc_o : '0;
        t_adr_o    = m_adr_i;
        t_sel_o    = m_sel_i;
        t_dat_o    = m_dat_i;
        m_ack_o    = live & rsp_ack & ~rsp_err;
        m_err_o    = (live & (rsp_err | tmo)) | (state_q == S_DECERR);
        m_dat_o    = (state_q == S_ACTIVE) ? t_dat_a[sel_q] : '0;
        err_code_d = (state_q == S_DECERR) ? ERR_DECODE : tmo ? ERR_TIMEOUT : ERR_TARGET;
        state_d    = (state_q == S_IDLE) ? (req ? (dec_hit ? S_ACTIVE : S_DECERR) : S_IDLE)
                   : (state_q == S_ACTIVE) ? ((!m_cyc_i || rsp_ack || rsp_err || tmo) ? S_IDLE : S_ACTIVE)
                   : S_IDLE;
    end

    // FSM state, decode capture and saturating watchdog counter (zero whenever not ACTIVE)
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            adr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && req) begin
                sel_q <= dec_idx;
                adr_q <= m_adr_i;
            end
            cnt_q <= (state_q != S_ACTIVE) ? '0 : (&cnt_q) ? cnt_q : cnt_q + 1'b1;
        end
    end

    // Error log: one-cycle strobe after every error returned to the initiator, code and address held
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            err_stb_o  <= 1'b0;
            err_code_o <= ERR_NONE;
            err_adr_o  <= '0;
        end else begin
            err_stb_o <= m_err_o;
            if (m_err_o) begin
                err_code_o <= err_code_d;
                err_adr_o  <= adr_q;
            end
        end
    end
endmodule
